// File: rtl/mb_pixel_fetch.sv
// Fetches an NV12 frame macroblock by macroblock (32 luma words then 16 UV words each) and streams it to cur_mb.
// Optional downstream starvation counter is compiled in when MB_FETCH_STALL_CNT_EN is defined.
module mb_pixel_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  mb_x_max_i,
    input  logic [7:0]  mb_y_max_i,
    input  logic [31:0] base_y_i,
    input  logic [31:0] base_uv_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic        rd_vld_i,
    input  logic [63:0] rd_data_i,
    input  logic        pinc_i,
    output logic        pvalid_o,
    output logic [63:0] pdata_o,
    output logic        busy_o,
    output logic        mb_done_o,
    output logic [31:0] stall_cnt_o,
    output logic [1:0]  dbg_state
);

    // Read port: a request transfers on a rising edge with rd_req_o && rd_gnt_i; rd_req_o/rd_addr_o hold
    // until then. Each rd_vld_i cycle returns one word, in request order; pops happen on pinc_i && !empty.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  x_max;
    logic [7:0]  y_max;
    logic [31:0] base_y;
    logic [31:0] base_uv;
    logic [31:0] stride;
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
    logic [5:0]  word_k;
    logic [4:0]  outstanding;

    logic [63:0] fifo_mem [0:15];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;
    logic [5:0]  out_k;

    logic        start_acc;
    logic        credit_ok;
    logic        fire;
    logic        last_word;
    logic        last_mb;
    logic        push;
    logic        pop;
    logic        is_luma;
    logic [31:0] row_off;
    logic [31:0] row;
    logic [31:0] addr;

    function automatic logic [63:0] byte_swap(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    assign start_acc = (state == S_IDLE) && start_i;
    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < 6'd16;
    assign rd_req_o  = (state == S_FETCH) && credit_ok;
    assign fire      = rd_req_o && rd_gnt_i;
    assign last_word = (word_k == 6'd47);
    assign last_mb   = (mb_x == x_max) && (mb_y == y_max);
    // Returns with nothing outstanding belong to requests issued before a reset and are dropped.
    assign push      = rd_vld_i && (outstanding != 5'd0);
    assign pop       = pinc_i && (count != 5'd0);

    // Word k < 32 is luma row k>>1; words 32..47 are UV rows, both split into two 8-byte halves.
    always_comb begin
        is_luma = ~word_k[5];
        row_off = is_luma ? {28'd0, word_k[4:1]} : {29'd0, word_k[3:1]};
        row     = is_luma ? (({24'd0, mb_y} << 4) + row_off) : (({24'd0, mb_y} << 3) + row_off);
        addr    = (is_luma ? base_y : base_uv) + row * stride + ({24'd0, mb_x} << 4)
                  + {28'd0, word_k[0], 3'd0};
    end

    assign rd_addr_o = (state == S_FETCH) ? addr : 32'd0;
    assign busy_o    = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_FETCH;
            S_FETCH: if (fire && last_word && last_mb) state_nxt = S_DRAIN;
            S_DRAIN: if ((count == 5'd0) && (outstanding == 5'd0)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            x_max       <= '0;
            y_max       <= '0;
            base_y      <= '0;
            base_uv     <= '0;
            stride      <= '0;
            mb_x        <= '0;
            mb_y        <= '0;
            word_k      <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                x_max   <= mb_x_max_i;
                y_max   <= mb_y_max_i;
                base_y  <= base_y_i;
                base_uv <= base_uv_i;
                stride  <= ({24'd0, mb_x_max_i} + 32'd1) << 4;
                mb_x    <= '0;
                mb_y    <= '0;
                word_k  <= '0;
            end else if (fire) begin
                if (last_word) begin
                    word_k <= '0;
                    if (mb_x == x_max) begin
                        mb_x <= '0;
                        mb_y <= mb_y + 8'd1;
                    end else begin
                        mb_x <= mb_x + 8'd1;
                    end
                end else begin
                    word_k <= word_k + 6'd1;
                end
            end
            case ({fire, push})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= byte_swap(rd_data_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_k     <= '0;
            pvalid_o  <= 1'b0;
            mb_done_o <= 1'b0;
            pdata_o   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            pvalid_o  <= pop;
            mb_done_o <= pop && (out_k == 6'd47);
            if (pop) begin
                pdata_o <= fifo_mem[rd_ptr];
                out_k   <= (out_k == 6'd47) ? 6'd0 : out_k + 6'd1;
            end
        end
    end

`ifdef MB_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (busy_o && pinc_i && (count == 5'd0) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mb_pixel_fetch.sv
// Directed + randomized bench for mb_pixel_fetch: memory responder, FIFO/credit reference model and scoreboards.
module tb_mb_pixel_fetch;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  mb_x_max_i;
    logic [7:0]  mb_y_max_i;
    logic [31:0] base_y_i;
    logic [31:0] base_uv_i;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_gnt_i;
    logic        rd_vld_i;
    logic [63:0] rd_data_i;
    logic        pinc_i;
    logic        pvalid_o;
    logic [63:0] pdata_o;
    logic        busy_o;
    logic        mb_done_o;
    logic [31:0] stall_cnt_o;
    logic [1:0]  dbg_state;

    mb_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mb_x_max_i  (mb_x_max_i),
        .mb_y_max_i  (mb_y_max_i),
        .base_y_i    (base_y_i),
        .base_uv_i   (base_uv_i),
        .rd_req_o    (rd_req_o),
        .rd_addr_o   (rd_addr_o),
        .rd_gnt_i    (rd_gnt_i),
        .rd_vld_i    (rd_vld_i),
        .rd_data_i   (rd_data_i),
        .pinc_i      (pinc_i),
        .pvalid_o    (pvalid_o),
        .pdata_o     (pdata_o),
        .busy_o      (busy_o),
        .mb_done_o   (mb_done_o),
        .stall_cnt_o (stall_cnt_o),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // scoreboard queues
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_pix_q[$];
    logic [31:0] addr_log[$];
    logic [63:0] ret_data_q[$];
    int          ret_due_q[$];
    int          last_due = 0;

    // reference model state
    int   m_out = 0;
    int   m_occ = 0;
    int   m_stall = 0;
    bit   m_busy = 0;
    bit   m_pop_pending = 0;
    bit   m_req_exp = 0;
    int   words_out = 0;
    int   done_cnt = 0;
    int   grant_cnt = 0;
    int   pv_cnt = 0;
    int   frame_mbs = 0;
    logic [63:0] first_pix = '0;

    // stimulus knobs
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          pinc_mode = 1;
    bit          const_data = 0;
    logic [63:0] mem_seed = 64'h0123_4567_89AB_CDEF;
    bit          drv_start = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (const_data) return 64'h0706_0504_0302_0100;
        return {a ^ mem_seed[63:32], (~a) ^ mem_seed[31:0]};
    endfunction

    // Pixel at the lowest address goes to the most significant byte of the delivered word.
    function automatic logic [63:0] pix_of(input logic [63:0] d);
        logic [63:0] r;
        logic [7:0]  p;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            p = d[8*i +: 8];
            r = (r << 8) | {56'd0, p};
        end
        return r;
    endfunction

    // One clock: check what the edge produced, then drive the next edge and advance the model.
    task automatic step();
        bit          gnt, pinc, vld, acc, push, pop, done_exp;
        logic [63:0] vdata;
        logic [63:0] exp_pix;
        logic [31:0] exp_a;
        int          lat, due, occ0, out0, left0;
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", busy_o, m_busy);
        chk("pvalid", pvalid_o, m_pop_pending);
        done_exp = 0;
        if (m_pop_pending) begin
            words_out++;
            pv_cnt++;
            exp_pix = 64'hDEAD_DEAD_DEAD_DEAD;
            if (exp_pix_q.size() != 0) exp_pix = exp_pix_q.pop_front();
            chk("pdata", pdata_o, exp_pix);
            if (words_out == 1) first_pix = pdata_o;
            done_exp = ((words_out % 48) == 0);
        end
        chk("mb_done", mb_done_o, done_exp);
        if (mb_done_o) done_cnt++;
        chk("rd_req", rd_req_o, m_req_exp);
`ifdef MB_FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
`else
        chk("stall_cnt", stall_cnt_o, 64'd0);
`endif

        gnt = ($urandom_range(0, 99) < gnt_pct);
        case (pinc_mode)
            0:       pinc = 0;
            1:       pinc = 1;
            default: pinc = $urandom_range(0, 1);
        endcase
        vld   = 0;
        vdata = {$urandom, $urandom};
        if (ret_due_q.size() != 0 && ret_due_q[0] <= cyc + 1) begin
            vld   = 1;
            vdata = ret_data_q.pop_front();
            void'(ret_due_q.pop_front());
        end
        occ0  = m_occ;
        out0  = m_out;
        left0 = exp_addr_q.size();
        acc   = rd_req_o && gnt;
        if (acc) begin
            exp_a = 32'hDEAD_BEEF;
            if (exp_addr_q.size() != 0) exp_a = exp_addr_q.pop_front();
            chk("rd_addr", rd_addr_o, exp_a);
            addr_log.push_back(rd_addr_o);
            grant_cnt++;
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_due_q.push_back(due);
            ret_data_q.push_back(mem_word(rd_addr_o));
        end
        push = vld && (out0 > 0);
        pop  = pinc && (occ0 > 0);
        if (m_busy && pinc && occ0 == 0) m_stall++;
        m_out = out0 + int'(acc) - int'(push);
        m_occ = occ0 + int'(push) - int'(pop);
        m_pop_pending = pop;
        if (drv_start && !m_busy) begin
            m_busy  = 1;
            m_stall = 0;
        end else if (m_busy && left0 == 0 && occ0 == 0 && out0 == 0) begin
            m_busy = 0;
        end
        m_req_exp = m_busy && (exp_addr_q.size() != 0) && (m_out + m_occ < 16);

        rd_gnt_i  = gnt;
        pinc_i    = pinc;
        rd_vld_i  = vld;
        rd_data_i = vdata;
        start_i   = drv_start;
        drv_start = 0;
    endtask

    task automatic do_reset(input int ncyc);
        #2;
        rst       = 1'b1;
        start_i   = 1'b0;
        rd_gnt_i  = 1'b0;
        rd_vld_i  = 1'b0;
        pinc_i    = 1'b0;
        drv_start = 0;
        #1;
        chk("rst_rd_req", rd_req_o, 64'd0);
        chk("rst_rd_addr", rd_addr_o, 64'd0);
        chk("rst_pvalid", pvalid_o, 64'd0);
        chk("rst_pdata", pdata_o, 64'd0);
        chk("rst_busy", busy_o, 64'd0);
        chk("rst_mb_done", mb_done_o, 64'd0);
        chk("rst_stall", stall_cnt_o, 64'd0);
        chk("rst_state", dbg_state, 64'd0);
        repeat (ncyc) @(posedge clk);
        #2;
        rst = 1'b0;
        m_out = 0;
        m_occ = 0;
        m_stall = 0;
        m_busy = 0;
        m_pop_pending = 0;
        m_req_exp = 0;
        words_out = 0;
        exp_addr_q.delete();
        exp_pix_q.delete();
    endtask

    task automatic begin_frame(input logic [7:0] xm, input logic [7:0] ym,
                               input logic [31:0] by, input logic [31:0] buv);
        logic [31:0] stride, a;
        stride = (int'(xm) + 1) * 16;
        exp_addr_q.delete();
        exp_pix_q.delete();
        for (int my = 0; my <= int'(ym); my++) begin
            for (int mx = 0; mx <= int'(xm); mx++) begin
                for (int k = 0; k < 48; k++) begin
                    if (k < 32) a = by + (my * 16 + k / 2) * stride + mx * 16 + (k % 2) * 8;
                    else        a = buv + (my * 8 + (k - 32) / 2) * stride + mx * 16 + (k % 2) * 8;
                    exp_addr_q.push_back(a);
                    exp_pix_q.push_back(pix_of(mem_word(a)));
                end
            end
        end
        frame_mbs  = (int'(xm) + 1) * (int'(ym) + 1);
        mb_x_max_i = xm;
        mb_y_max_i = ym;
        base_y_i   = by;
        base_uv_i  = buv;
        words_out  = 0;
        done_cnt   = 0;
        grant_cnt  = 0;
        pv_cnt     = 0;
        addr_log.delete();
        drv_start  = 1;
    endtask

    task automatic finish_frame(input int max_cyc);
        int n;
        step();
        n = 1;
        while (m_busy && n < max_cyc) begin
            step();
            n++;
        end
        chk("frame_in_budget", n < max_cyc, 64'd1);
        repeat (3) step();
        chk("words_delivered", words_out, frame_mbs * 48);
        chk("mb_done_count", done_cnt, frame_mbs);
    endtask

    initial begin
        logic [31:0] by, buv;
        int n;
        rst = 1'b0; start_i = 1'b0; rd_gnt_i = 1'b0; rd_vld_i = 1'b0; pinc_i = 1'b0;
        rd_data_i = '0; mb_x_max_i = '0; mb_y_max_i = '0; base_y_i = '0; base_uv_i = '0;
        #1;
        do_reset(4);
        repeat (2) step();

        // 1x1 frame, unity latency, constant memory pattern
        const_data = 1; gnt_pct = 100; lat_min = 1; lat_max = 1; pinc_mode = 1;
        begin_frame(8'd0, 8'd0, 32'h1000, 32'h2000);
        finish_frame(2000);
        chk("addr_w0", addr_log[0], 64'h1000);
        chk("addr_w1", addr_log[1], 64'h1008);
        chk("addr_w31", addr_log[31], 64'h10F8);
        chk("addr_w32", addr_log[32], 64'h2000);
        chk("addr_w47", addr_log[47], 64'h2078);
        chk("grants_1x1", grant_cnt, 64'd48);
        chk("pvalids_1x1", pv_cnt, 64'd48);
        chk("byte_order", first_pix, 64'h0001_0203_0405_0607);
        const_data = 0;

        // 2x2 frame, random handshakes, late start pulse that must be ignored
        mem_seed = {$urandom, $urandom}; gnt_pct = 70; lat_min = 1; lat_max = 6; pinc_mode = 2;
        by  = $urandom & 32'hFFFF_FFF8;
        buv = $urandom & 32'hFFFF_FFF8;
        begin_frame(8'd1, 8'd1, by, buv);
        step();
        repeat (20) step();
        mb_x_max_i = 8'($urandom); mb_y_max_i = 8'($urandom);
        base_y_i = $urandom; base_uv_i = $urandom;
        drv_start = 1;
        finish_frame(5000);
        chk("mb10_first_luma", addr_log[48], by + 32'd16);
        chk("mb01_first_luma", addr_log[96], by + 32'd512);

        // downstream blocked for 100 cycles
        gnt_pct = 100; lat_min = 2; lat_max = 2; pinc_mode = 0;
        begin_frame(8'd2, 8'd1, $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8);
        step();
        repeat (100) step();
        chk("grants_blocked", grant_cnt, 64'd16);
        chk("pvalid_blocked", pv_cnt, 64'd0);
        pinc_mode = 1;
        finish_frame(5000);

        // random frames, including a base that wraps past 2^32
        for (int t = 0; t < 3; t++) begin
            mem_seed = {$urandom, $urandom};
            gnt_pct = $urandom_range(50, 100); lat_min = 1; lat_max = $urandom_range(1, 8); pinc_mode = 2;
            by  = (t == 0) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FFF8);
            buv = $urandom & 32'hFFFF_FFF8;
            begin_frame(8'($urandom_range(0, 3)), 8'($urandom_range(0, 2)), by, buv);
            finish_frame(20000);
        end

        // reset in the middle of a frame with reads in flight
        gnt_pct = 100; lat_min = 3; lat_max = 3; pinc_mode = 1;
        begin_frame(8'd0, 8'd0, $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8);
        step();
        n = 0;
        while (words_out < 20 && n < 500) begin
            step();
            n++;
        end
        chk("reached_word20", words_out >= 20, 64'd1);
        do_reset(3);
        n = 0;
        while (ret_due_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        mem_seed = {$urandom, $urandom};
        by  = $urandom & 32'hFFFF_FFF8;
        buv = $urandom & 32'hFFFF_FFF8;
        begin_frame(8'd0, 8'd0, by, buv);
        finish_frame(2000);
        chk("first_word_after_reset", first_pix, pix_of(mem_word(by)));

        // long read latency starves the consumer
        gnt_pct = 100; lat_min = 10; lat_max = 10; pinc_mode = 1;
        begin_frame(8'd0, 8'd0, $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8);
        finish_frame(5000);
`ifdef MB_FETCH_STALL_CNT_EN
        chk("stall_nonzero", stall_cnt_o != 32'd0, 64'd1);
        chk("stall_final", stall_cnt_o, m_stall);
`else
        chk("stall_absent", stall_cnt_o, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mb_pixel_fetch.md
MB_PIXEL_FETCH -- requirements
Module: mb_pixel_fetch

Interface
REQ-001 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-002 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-003 start_i  input  1  one-cycle pulse; starts fetching one frame.
REQ-004 mb_x_max_i  input  8  macroblock columns minus 1; sampled at start.
REQ-005 mb_y_max_i  input  8  macroblock rows minus 1; sampled at start.
REQ-006 base_y_i, base_uv_i  input  32 each  byte base addresses of the NV12 luma and UV planes; sampled at start.
REQ-007 rd_req_o  output  1  memory read request.
REQ-008 rd_addr_o  output  32  8-byte-aligned byte address.
REQ-009 rd_gnt_i  input  1  request is accepted in a cycle where rd_req_o and rd_gnt_i are both 1.
REQ-010 rd_vld_i  input  1  read data valid; data returns in request order with any latency.
REQ-011 rd_data_i  input  64  read data; the byte at the lowest address is in [7:0].
REQ-012 pinc_i  input  1  downstream read-enable (from cur_mb pinc_o).
REQ-013 pvalid_o  output  1  one-cycle strobe per word delivered.
REQ-014 pdata_o  output  64  word to cur_mb; the lowest-address pixel is in [63:56].
REQ-015 busy_o  output  1  high from start until the frame is complete.
REQ-016 mb_done_o  output  1  one-cycle pulse after the 48th word of each MB is delivered.
REQ-017 stall_cnt_o  output  32  downstream starvation counter (see Configuration).

Function
REQ-018 Each MB SHALL be 48 words in this order: 32 luma words, then 16 UV words.
REQ-019 Luma word k (0..31): row r=k>>1, half h=k&1; address = base_y + (mb_y*16+r)*stride + mb_x*16 + h*8.
REQ-020 UV word k (0..15): row r=k>>1, h=k&1; address = base_uv + (mb_y*8+r)*stride + mb_x*16 + h*8.
REQ-021 stride SHALL be (mb_x_max+1)*16; all address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-022 MB order SHALL be raster: mb_x 0..mb_x_max, then mb_y+1; fetch SHALL run across MB boundaries without gaps.
REQ-023 An internal FIFO of 16 x 64 bits SHALL buffer returned data, byte-reversed per REQ-011/REQ-014.
REQ-024 Credit rule: rd_req_o SHALL be asserted only if (outstanding reads + FIFO occupancy) < 16.
REQ-025 rd_req_o and rd_addr_o SHALL hold stable until the request is granted.
REQ-026 A pop SHALL occur in a cycle where pinc_i=1 and the FIFO is not empty; pvalid_o/pdata_o SHALL be registered, one cycle after the pop.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; a full FIFO SHALL never be written, guaranteed by REQ-024.
REQ-028 FSM states: IDLE -> (start_i) FETCH -> (last request of last MB granted) DRAIN -> (FIFO empty, outstanding=0, last pvalid_o issued) IDLE.
REQ-029 start_i SHALL be ignored outside IDLE.
REQ-030 busy_o SHALL be 1 in FETCH and DRAIN, and 0 in IDLE.
REQ-031 mb_done_o SHALL assert in the same cycle as the 48th pvalid_o of each MB.
REQ-032 A 1x1 frame (mb_x_max = mb_y_max = 0) SHALL produce exactly 48 words and one mb_done_o.

Reset
REQ-033 While rst=1: FSM=IDLE; FIFO, counters and credits cleared; rd_req_o, pvalid_o, mb_done_o, busy_o = 0; pdata_o = 0; rd_addr_o = 0; stall_cnt_o = 0.
REQ-034 Reset mid-frame SHALL abort immediately; rd_vld_i returns for requests issued before reset SHALL be discarded until outstanding reaches 0.

Configuration
REQ-035 Macro MB_FETCH_STALL_CNT_EN defined: stall_cnt_o SHALL increment (saturating at 2^32-1) each cycle where busy_o=1, pinc_i=1 and the FIFO is empty, and SHALL clear on an accepted start_i.
REQ-036 Macro MB_FETCH_STALL_CNT_EN undefined: stall_cnt_o SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-037 mb_x_max=0, mb_y_max=0, base_y=0x1000, base_uv=0x2000, gnt=1, read latency 1, pinc_i=1 -> addresses 0x1000, 0x1008, 0x1010, ... 0x10F8, then 0x2000 ... 0x2078; 48 pvalid_o; one mb_done_o; busy_o falls afterwards.
REQ-038 mb_x_max=1, mb_y_max=1 -> MB(1,0) first luma address = base_y+16; MB(0,1) first luma address = base_y+32*16; exactly 4 mb_done_o.
REQ-039 pinc_i=0 for 100 cycles after start -> at most 16 requests granted and 0 pvalid_o; releasing pinc_i resumes delivery with no word lost or duplicated.
REQ-040 rd_data_i=0x0706050403020100 -> pdata_o=0x0001020304050607.
REQ-041 rst pulsed during word 20, with 3 reads outstanding -> outputs return to 0 and the stale returns are dropped; a new start_i delivers the correct first word.
REQ-042 With MB_FETCH_STALL_CNT_EN: read latency 10, pinc_i=1 -> stall_cnt_o is non-zero and matches the bench's count of empty-FIFO cycles; without the macro -> 0.
